systolic_2x2_seq: RTL and testbench
===================================

# systolic_2x2_seq

Job sequencer for the `systolic_2x2` array. It accepts one pair of 2x2 operand matrices over a valid/ready handshake and clears the array. It then drives the four skewed wavefronts with single-cycle `load_in` pulses, waits for the array to drain, and returns the four 64-bit results and carries over a second valid/ready handshake. It replaces hand-sequenced stimulus and sits between the matrix job source and the array.

## Interface
- `DATA_W`, 32, operand element width
- `RES_W`, 64, result element width
- `CLR_CYCLES`, 2, array-clear pulse length; legal range ≥1
- `WAVE_GAP`, 20, cycles from one load pulse to the next; legal range ≥2
- `DRAIN_CYCLES`, 200, cycles from the last load pulse to result capture; legal range ≥1

- `clk` in 1: clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `job_valid` in 1: operand pair offered
- `job_ready` out 1: sequencer idle, accepts a job
- `a_mat` in 4*DATA_W: {a22,a21,a12,a11}, with a11 in the LSBs
- `b_mat` in 4*DATA_W: {b22,b21,b12,b11}
- `arr_rst` out 1: active-high array reset
- `arr_load` out 1: array `load_in`
- `arr_row0`, `arr_row1`, `arr_col0`, `arr_col1` out DATA_W: array row/col inputs
- `arr_res` in 4*RES_W: {r11,r10,r01,r00} from the array
- `arr_carry` in 4: {c11,c10,c01,c00}
- `res_valid` out 1: results held
- `res_ready` in 1: consumer takes results
- `res_mat` out 4*RES_W: captured results
- `res_carry` out 4: captured carries
- `busy` out 1: high in every state except IDLE

## Operation
- States: IDLE → CLEAR → WAVE → DRAIN → OUT → IDLE.
- **IDLE**
  - `job_ready`=1.
  - On `job_valid && job_ready`, latch `a_mat`/`b_mat` and go to CLEAR.
- **CLEAR**
  - `arr_rst`=1 for exactly CLR_CYCLES cycles, then go to WAVE with wave index k=0.
- **WAVE**
  - On entry to each wave k, pulse `arr_load` for one cycle and update the row/col registers.
  - Row/col registers hold their value until the next wave.
  - Wave 0: row0=a12, row1=0, col0=b21, col1=0.
  - Wave 1: row0=a11, row1=a22, col0=b11, col1=b22.
  - Wave 2: row0=0, row1=a21, col0=0, col1=b12.
  - Wave 3: all zero.
  - A gap counter counts WAVE_GAP cycles between pulses. After wave 3, go to DRAIN.
- **DRAIN**
  - Count DRAIN_CYCLES, then capture `arr_res` and `arr_carry` into the output registers and go to OUT.
- **OUT**
  - `res_valid`=1, with `res_mat` and `res_carry` stable.
  - On `res_valid && res_ready`, go to IDLE.
  - `job_valid` is ignored in OUT; `job_ready`=0.
- No arithmetic in the base block. Operands pass through unmodified and results are captured verbatim.

## Timing
- Reset values: `job_ready`=0 while `rst_n` is low and 1 from the first edge after release; `arr_rst`=1; all other outputs 0; state=IDLE.
- Let T be the job-accept edge.
  - `arr_rst` is high on cycles T+1 … T+CLR_CYCLES.
  - Wave k pulse is on cycle P_k = T+CLR_CYCLES+1+k*WAVE_GAP.
  - Results are captured on the edge ending cycle P_3+DRAIN_CYCLES.
  - `res_valid` rises on cycle P_3+DRAIN_CYCLES+1.
- With the defaults, `res_valid` rises 263 cycles after accept.
- Back-to-back jobs:
  - `job_ready` returns in the cycle after the result handshake.
  - A `job_valid` held across OUT is accepted on that cycle, never earlier.
- `res_ready` held high before `res_valid` causes OUT to last exactly one cycle.
- `rst_n` asserted in any state aborts the job immediately. The latched operands are discarded and `arr_rst` goes to 1 asynchronously.
- `arr_rst` and `arr_load` are never high in the same cycle.

## Configuration
- `SYS2X2_SELFCHECK_EN` defined:
  - Adds output `res_mismatch` (4 bits).
  - Computes the expected product from the latched operands, e.g. r00=a11*b11+a12*b21, as unsigned values truncated to RES_W.
  - Compares each element against the captured `res_mat` at capture. Mismatch bits are valid with `res_valid` and reset to 0.
- Undefined: the port and the multipliers are absent; behaviour is otherwise identical.

## Structure
- Package `systolic_2x2_pkg`:
  - State enum.
  - Wave-index type.
  - Default DATA_W/RES_W constants.
  - Element-slice helper functions for the packed matrix buses.
- One sub-module `systolic_2x2_wave_mux`: combinational selection of the four row/col values from wave index k and the latched operands.
- The FSM, counters, result register and optional self-check live in the top module.

## Test plan
- A=B=[1 2;3 4] (a11=1,a12=2,a21=3,a22=4), real array, `res_ready`=1 → res_mat={22,15,10,7}, carries 0, `res_valid` exactly 263 cycles after accept.
- Same job with `res_ready` low for 50 cycles after `res_valid` → outputs stable, `job_ready`=0 throughout, single handshake, then IDLE.
- Two jobs (identity × B, then A×A) with `job_valid` held high → second accept on the cycle after the first result handshake; results B, then {22,15,10,7}. CLEAR precedes job 2, so no accumulation carries over.
- `rst_n` pulsed low during wave 2 → `arr_rst`=1 and `arr_load`=0 immediately, `res_valid` never asserted. A new job then completes correctly.
- All operands 0xFFFFFFFF → each element equals 2*(2^32-1)^2 mod 2^64 = 0xFFFFFFFC00000002, with the array's carry bits propagated unchanged.
- With `SYS2X2_SELFCHECK_EN`, an array model returns r10=16 instead of 15 → `res_mismatch`=4'b0100; a correct model → 4'b0000.

Source files
------------

// File: rtl/systolic_2x2_seq_pkg.sv
// systolic_2x2_pkg: shared types, default widths and bus slicing helpers for the 2x2 job sequencer
package systolic_2x2_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int RES_W_DEF  = 64;
   localparam int ELEM_MAX   = 64;
   localparam int BUS_MAX    = 4 * ELEM_MAX;
   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WAVE, S_DRAIN, S_OUT} state_t;
   typedef logic [1:0] wave_t;
   function automatic logic [ELEM_MAX-1:0] elem(input logic [BUS_MAX-1:0] m, input int w, input int i);
      logic [BUS_MAX-1:0] s;
      s = m >> (w * i);
      return s[ELEM_MAX-1:0];
   endfunction
endpackage

// File: rtl/systolic_2x2_seq_if.sv
// systolic_2x2_seq_if: job and result valid/ready buses of the 2x2 sequencer
interface systolic_2x2_seq_if
   import systolic_2x2_pkg::*;
#(parameter int DATA_W = DATA_W_DEF, parameter int RES_W = RES_W_DEF);
   logic                job_valid, job_ready;
   logic [4*DATA_W-1:0] a_mat, b_mat;
   logic                res_valid, res_ready;
   logic [4*RES_W-1:0]  res_mat;
   logic [3:0]          res_carry;
   modport master (output job_valid, a_mat, b_mat, res_ready, input job_ready, res_valid, res_mat, res_carry);
   modport slave  (input job_valid, a_mat, b_mat, res_ready, output job_ready, res_valid, res_mat, res_carry);
endinterface

// File: rtl/systolic_2x2_seq_wave_mux.sv
// systolic_2x2_wave_mux: picks the skewed row/col operands driven on wave k
module systolic_2x2_wave_mux
   import systolic_2x2_pkg::*;
#(parameter int DATA_W = DATA_W_DEF)(
   input  wave_t               i_k,
   input  logic [4*DATA_W-1:0] i_a,
   input  logic [4*DATA_W-1:0] i_b,
   output logic [DATA_W-1:0]   o_row0,
   output logic [DATA_W-1:0]   o_row1,
   output logic [DATA_W-1:0]   o_col0,
   output logic [DATA_W-1:0]   o_col1
);
   logic [DATA_W-1:0] w_a [4];
   logic [DATA_W-1:0] w_b [4];
   // element order is {x22,x21,x12,x11}; row 0 leads row 1 and col 0 leads col 1 by one wave
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_a[i] = DATA_W'(elem(BUS_MAX'(i_a), DATA_W, i));
         w_b[i] = DATA_W'(elem(BUS_MAX'(i_b), DATA_W, i));
      end
      o_row0 = i_k == 2'd0 ? w_a[1] : i_k == 2'd1 ? w_a[0] : '0;
      o_row1 = i_k == 2'd1 ? w_a[3] : i_k == 2'd2 ? w_a[2] : '0;
      o_col0 = i_k == 2'd0 ? w_b[2] : i_k == 2'd1 ? w_b[0] : '0;
      o_col1 = i_k == 2'd1 ? w_b[3] : i_k == 2'd2 ? w_b[1] : '0;
   end
endmodule

// File: rtl/systolic_2x2_seq.sv
// systolic_2x2_seq: clears the 2x2 array, drives four skewed wavefronts, drains and returns results; SYS2X2_SELFCHECK_EN adds res_mismatch
module systolic_2x2_seq
   import systolic_2x2_pkg::*;
#(
   parameter int DATA_W       = DATA_W_DEF,
   parameter int RES_W        = RES_W_DEF,
   parameter int CLR_CYCLES   = 2,
   parameter int WAVE_GAP     = 20,
   parameter int DRAIN_CYCLES = 200
)(
   input  logic                clk,
   input  logic                rst_n,
   systolic_2x2_seq_if.slave   bus,
   output logic                arr_rst,
   output logic                arr_load,
   output logic [DATA_W-1:0]   arr_row0,
   output logic [DATA_W-1:0]   arr_row1,
   output logic [DATA_W-1:0]   arr_col0,
   output logic [DATA_W-1:0]   arr_col1,
   input  logic [4*RES_W-1:0]  arr_res,
   input  logic [3:0]          arr_carry,
   output logic                busy
`ifdef SYS2X2_SELFCHECK_EN
   , output logic [3:0]        res_mismatch
`endif
);
   state_t              r_state, w_state_nxt;
   logic [31:0]         r_cnt, w_cnt_nxt;
   wave_t               r_k, w_k_nxt;
   logic                w_load_nxt, w_acc, w_cap;
   logic                r_job_ready, r_arr_rst, r_load, r_res_valid;
   logic [4*DATA_W-1:0] r_a, r_b;
   logic [DATA_W-1:0]   r_row0, r_row1, r_col0, r_col1;
   logic [DATA_W-1:0]   w_row0, w_row1, w_col0, w_col1;
   logic [4*RES_W-1:0]  r_res;
   logic [3:0]          r_carry;

   systolic_2x2_wave_mux #(.DATA_W(DATA_W)) u_mux (
      .i_k(w_k_nxt), .i_a(r_a), .i_b(r_b),
      .o_row0(w_row0), .o_row1(w_row1), .o_col0(w_col0), .o_col1(w_col1)
   );

   // state, shared cycle counter and wave index
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_k     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_k     <= w_k_nxt;
      end

   // sequencing: every state entry restarts the counter; a load is scheduled on the edge entering each wave
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 32'd1;
      w_k_nxt     = r_k;
      w_load_nxt  = 1'b0;
      w_acc       = 1'b0;
      w_cap       = 1'b0;
      case (r_state)
         S_IDLE: if (bus.job_valid && r_job_ready) begin
            w_state_nxt = S_CLEAR;
            w_cnt_nxt   = '0;
            w_acc       = 1'b1;
         end
         S_CLEAR: if (r_cnt == 32'(CLR_CYCLES - 1)) begin
            w_state_nxt = S_WAVE;
            w_cnt_nxt   = '0;
            w_k_nxt     = '0;
            w_load_nxt  = 1'b1;
         end
         S_WAVE: if (r_k == 2'd3) begin
            w_state_nxt = S_DRAIN;
            w_cnt_nxt   = '0;
         end else if (r_cnt == 32'(WAVE_GAP - 1)) begin
            w_cnt_nxt   = '0;
            w_k_nxt     = r_k + 2'd1;
            w_load_nxt  = 1'b1;
         end
         S_DRAIN: if (r_cnt == 32'(DRAIN_CYCLES - 1)) begin
            w_state_nxt = S_OUT;
            w_cap       = 1'b1;
         end
         S_OUT: if (bus.res_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // registered outputs, operand latch, wave operands and result capture
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_job_ready <= 1'b0;
         r_arr_rst   <= 1'b1;
         r_load      <= 1'b0;
         r_res_valid <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_row0      <= '0;
         r_row1      <= '0;
         r_col0      <= '0;
         r_col1      <= '0;
         r_res       <= '0;
         r_carry     <= '0;
      end else begin
         r_job_ready <= w_state_nxt == S_IDLE;
         r_arr_rst   <= w_state_nxt == S_CLEAR;
         r_load      <= w_load_nxt;
         r_res_valid <= w_state_nxt == S_OUT;
         if (w_acc) begin
            r_a <= bus.a_mat;
            r_b <= bus.b_mat;
         end
         if (w_load_nxt) begin
            r_row0 <= w_row0;
            r_row1 <= w_row1;
            r_col0 <= w_col0;
            r_col1 <= w_col1;
         end
         if (w_cap) begin
            r_res   <= arr_res;
            r_carry <= arr_carry;
         end
      end

   assign bus.job_ready = r_job_ready;
   assign bus.res_valid = r_res_valid;
   assign bus.res_mat   = r_res;
   assign bus.res_carry = r_carry;
   assign arr_rst       = r_arr_rst;
   assign arr_load      = r_load;
   assign arr_row0      = r_row0;
   assign arr_row1      = r_row1;
   assign arr_col0      = r_col0;
   assign arr_col1      = r_col1;
   assign busy          = r_state != S_IDLE;

`ifdef SYS2X2_SELFCHECK_EN
   logic [3:0] w_mis, r_mis;
   // element (i/2, i%2) of A*B in RES_W-bit unsigned arithmetic, compared with what the array returned
   always_comb begin
      w_mis = '0;
      for (int i = 0; i < 4; i++)
         w_mis[i] = RES_W'(DATA_W'(elem(BUS_MAX'(r_a), DATA_W, (i / 2) * 2))) * RES_W'(DATA_W'(elem(BUS_MAX'(r_b), DATA_W, i % 2)))
                  + RES_W'(DATA_W'(elem(BUS_MAX'(r_a), DATA_W, (i / 2) * 2 + 1))) * RES_W'(DATA_W'(elem(BUS_MAX'(r_b), DATA_W, 2 + i % 2)))
                  != RES_W'(elem(BUS_MAX'(arr_res), RES_W, i));
   end
   // mismatch flags are captured alongside the results
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_mis <= '0;
      else if (w_cap) r_mis <= w_mis;
   assign res_mismatch = r_mis;
`endif
endmodule

// File: tb/tb_systolic_2x2_seq.sv
// tb_systolic_2x2_seq: directed and random jobs through the sequencer driving a behavioural skewed 2x2 array
module tb_systolic_2x2_seq;
   localparam int CLR    = 2;
   localparam int GAP    = 20;
   localparam int DRAIN  = 200;
   localparam int RV_OFF = CLR + 1 + 3 * GAP + DRAIN;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        arr_rst, arr_load, busy;
   logic [31:0] arr_row0, arr_row1, arr_col0, arr_col1;
   logic [255:0] arr_res;
   logic [3:0]  arr_carry;
   int          checks = 0;
   int          failures = 0;
   bit          corrupt = 1'b0;
`ifdef SYS2X2_SELFCHECK_EN
   logic [3:0]  mis;
`endif

   systolic_2x2_seq_if bus ();

   systolic_2x2_seq dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .arr_rst(arr_rst), .arr_load(arr_load),
      .arr_row0(arr_row0), .arr_row1(arr_row1), .arr_col0(arr_col0), .arr_col1(arr_col1),
      .arr_res(arr_res), .arr_carry(arr_carry), .busy(busy)
`ifdef SYS2X2_SELFCHECK_EN
      , .res_mismatch(mis)
`endif
   );

   always #5 clk = ~clk;

   // behavioural array: PE(i,j) multiplies row i and col j, with row 1 and col 1 arriving one wave late
   logic [63:0] m_acc [4];
   logic [3:0]  m_cy;
   logic [31:0] m_r0, m_r1, m_c0, m_c1;
   logic [64:0] s [4];

   function automatic logic [64:0] acc65(input logic [63:0] acc, input logic [31:0] x, input logic [31:0] y);
      return 65'(acc) + 65'(x) * 65'(y);
   endfunction

   assign s[0] = acc65(m_acc[0], arr_row0, arr_col0);
   assign s[1] = acc65(m_acc[1], m_r0, arr_col1);
   assign s[2] = acc65(m_acc[2], arr_row1, m_c0);
   assign s[3] = acc65(m_acc[3], m_r1, m_c1);
   assign arr_res   = {m_acc[3], m_acc[2] + 64'(corrupt), m_acc[1], m_acc[0]};
   assign arr_carry = m_cy;

   always @(posedge clk)
      if (arr_rst) begin
         for (int i = 0; i < 4; i++) m_acc[i] <= '0;
         m_cy <= '0;
         m_r0 <= '0;
         m_r1 <= '0;
         m_c0 <= '0;
         m_c1 <= '0;
      end else if (arr_load) begin
         for (int i = 0; i < 4; i++) begin
            m_acc[i] <= s[i][63:0];
            m_cy[i]  <= m_cy[i] | s[i][64];
         end
         m_r0 <= arr_row0;
         m_r1 <= arr_row1;
         m_c0 <= arr_col0;
         m_c1 <= arr_col1;
      end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // plain matrix product C = A*B, elements truncated to 64 bits, carry = sum overflowed
   function automatic void ref_mul(input logic [127:0] a, input logic [127:0] b, input bit cor,
                                   output logic [255:0] r, output logic [3:0] c);
      logic [127:0] t;
      r = '0;
      c = '0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            t = 128'(a[(2*i)*32 +: 32]) * 128'(b[j*32 +: 32]) + 128'(a[(2*i+1)*32 +: 32]) * 128'(b[(2+j)*32 +: 32]);
            r[(2*i+j)*64 +: 64] = t[63:0];
            c[2*i+j] = t[127:64] != 0;
         end
      if (cor) r[128 +: 64] = r[128 +: 64] + 64'd1;
   endfunction

   task automatic run_job(input logic [127:0] a, input logic [127:0] b, input int hold,
                          input bit chain, input logic [127:0] na, input logic [127:0] nb, input bit imm);
      logic [255:0] er;
      logic [3:0]   ec;
      int           n, se;
      ref_mul(a, b, corrupt, er, ec);
      bus.a_mat = a;
      bus.b_mat = b;
      bus.job_valid = 1'b1;
      bus.res_ready = hold == 0;
      n = 0;
      while (!bus.job_ready && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      if (imm) chk("b2b_wait", 256'(n), 256'(0));
      chk("accept_ready", 256'(bus.job_ready), 256'(1));
      @(posedge clk); #1;
      if (chain) begin
         bus.a_mat = na;
         bus.b_mat = nb;
      end else bus.job_valid = 1'b0;
      se = 0;
      for (int off = 0; off < RV_OFF; off++) begin
         se += int'(arr_rst !== (off < CLR));
         se += int'(arr_load !== (off >= CLR && (off - CLR) % GAP == 0 && (off - CLR) / GAP < 4));
         se += int'(bus.res_valid !== 1'b0) + int'(bus.job_ready !== 1'b0) + int'(busy !== 1'b1);
         @(posedge clk); #1;
      end
      chk("sequence", 256'(se), 256'(0));
      chk("res_valid_at_263", 256'(bus.res_valid), 256'(1));
      chk("res_mat", bus.res_mat, er);
      chk("res_carry", 256'(bus.res_carry), 256'(ec));
`ifdef SYS2X2_SELFCHECK_EN
      chk("res_mismatch", 256'(mis), corrupt ? 256'(4'b0100) : 256'(0));
`endif
      se = 0;
      for (int i = 0; i < hold; i++) begin
         se += int'(bus.res_mat !== er) + int'(bus.res_carry !== ec);
         se += int'(bus.res_valid !== 1'b1) + int'(bus.job_ready !== 1'b0) + int'(arr_load !== 1'b0);
         @(posedge clk); #1;
      end
      if (hold > 0) chk("hold_stable", 256'(se), 256'(0));
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      chk("out_exit", 256'({bus.res_valid, busy, bus.job_ready}), 256'(3'b001));
   endtask

   initial begin
      logic [127:0] aa, id, ff, ra, rb;
      int n, se;
      aa = {32'd4, 32'd3, 32'd2, 32'd1};
      id = {32'd1, 32'd0, 32'd0, 32'd1};
      ff = '1;
      bus.job_valid = 1'b0;
      bus.res_ready = 1'b0;
      bus.a_mat = '0;
      bus.b_mat = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outputs", 256'({bus.job_ready, arr_rst, arr_load, bus.res_valid, busy, bus.res_carry}), 256'(9'b010000000));
      chk("rst_res_mat", bus.res_mat, 256'(0));
      chk("rst_rows", 256'({arr_row0, arr_row1, arr_col0, arr_col1}), 256'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_rst", 256'({bus.job_ready, busy}), 256'(2'b10));

      run_job(aa, aa, 0, 1'b0, '0, '0, 1'b0);
      chk("aa_literal", bus.res_mat, {64'd22, 64'd15, 64'd10, 64'd7});
      run_job(aa, aa, 50, 1'b0, '0, '0, 1'b0);

      rb = {$urandom, $urandom, $urandom, $urandom};
      run_job(id, rb, 2, 1'b1, aa, aa, 1'b0);
      chk("identity_literal", bus.res_mat, {32'd0, rb[127:96], 32'd0, rb[95:64], 32'd0, rb[63:32], 32'd0, rb[31:0]});
      run_job(aa, aa, 0, 1'b0, '0, '0, 1'b1);

      bus.a_mat = aa;
      bus.b_mat = aa;
      bus.job_valid = 1'b1;
      bus.res_ready = 1'b1;
      n = 0;
      while (!bus.job_ready && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      bus.job_valid = 1'b0;
      repeat (CLR + 2 * GAP) begin
         @(posedge clk); #1;
      end
      chk("wave2_load", 256'(arr_load), 256'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("abort_outputs", 256'({arr_rst, arr_load, busy, bus.job_ready, bus.res_valid}), 256'(5'b10000));
      chk("abort_rows", 256'({arr_row0, arr_row1, arr_col0, arr_col1}), 256'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      se = 0;
      repeat (300) begin
         @(posedge clk); #1;
         se += int'(bus.res_valid !== 1'b0);
      end
      chk("abort_no_valid", 256'(se), 256'(0));
      run_job(aa, aa, 0, 1'b0, '0, '0, 1'b0);

      run_job(ff, ff, 1, 1'b0, '0, '0, 1'b0);
      chk("ones_literal", bus.res_mat, {4{64'hFFFFFFFC00000002}});
      chk("ones_carry", 256'(bus.res_carry), 256'(4'hF));

      for (int j = 0; j < 6; j++) begin
         ra = {$urandom, $urandom, $urandom, $urandom};
         rb = {$urandom, $urandom, $urandom, $urandom};
         run_job(ra, rb, int'($urandom_range(0, 3)), 1'b0, '0, '0, 1'b0);
      end

`ifdef SYS2X2_SELFCHECK_EN
      corrupt = 1'b1;
      run_job(aa, aa, 0, 1'b0, '0, '0, 1'b0);
      corrupt = 1'b0;
      run_job(aa, aa, 0, 1'b0, '0, '0, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
